i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

I2C target (slave) that emulates the MPU6050 register interface on the far end of the bus from our I2C master. It answers a programmable 7-bit device address and holds a 128 x 8 register file. The file is written by I2C register-write transactions and read back by I2C register-read transactions, with an auto-incrementing register pointer. A fabric-side port lets local logic load sensor registers and observe I2C writes, so the block serves both as a loopback target for the master and as a bench model.

## Interface
- DEV_ADDR, 7'h68: 7-bit address the block ACKs.
- WHOAMI_VAL, 8'h68: reset value of register 0x75; all other registers reset to 8'h00 except 0x6B = 8'h40.
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-low reset (low = reset).
- SCL  input  1  bus clock from the master, asynchronous to clk.
- SDA_in  input  1  sampled bus data line.
- SDA_out  output  1  data driven when Tristate=1; always 0, since the bus is open-drain.
- Tristate  output  1  1 = pull SDA low (ACK or a data 0); 0 = release SDA.
- host_we  input  1  fabric write strobe into the register file.
- host_addr  input  7  fabric write address.
- host_wdata  input  8  fabric write data.
- wr_strobe  output  1  one-cycle pulse on each completed I2C data-byte write.
- wr_addr  output  7  register written; valid with wr_strobe.
- wr_data  output  8  byte written; valid with wr_strobe.
- busy  output  1  high from an address-matched START until STOP.

## Operation
- Both SCL and SDA_in pass through 2-FF synchronizers, followed by one edge-detect register.
- Bus events are decoded from the synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bit sample: SCL rise.
  - Drive update: SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE -> ADDR on START.
- ADDR: shift in 8 bits, MSB first. If the top 7 bits equal DEV_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP and keep Tristate at 0.
- ADDR_ACK: drive ACK for one SCL period.
  - R/W=0 -> REG.
  - R/W=1 -> load the shift register from regfile[ptr], then go to RDATA.
- REG: shift 8 bits, ptr <= bits[6:0], bit 7 ignored. Then REG_ACK (ACK driven), then WDATA.
- WDATA: shift 8 bits, then WDATA_ACK (ACK driven).
  - On entry to WDATA_ACK: regfile[ptr] <= byte, pulse wr_strobe with wr_addr=ptr and wr_data=byte, then ptr <= ptr+1.
  - Return to WDATA for the next byte.
- RDATA: drive the MSB first. Tristate = ~bit, updated on each SCL fall. After 8 bits, go to RDATA_ACK with SDA released and sample the master's ACK on SCL rise.
  - ACK: ptr <= ptr+1, reload the shift register from regfile[ptr+1], then RDATA.
  - NACK: go to WAIT_STOP.
- START in any state (repeated start) -> ADDR, with ptr preserved. This supports the standard write-pointer / repeated-START / read sequence.
- STOP in any state -> IDLE, busy=0, Tristate=0.
- Pointer is 7 bits and wraps 0x7F -> 0x00.
- host_we writes regfile[host_addr] on the clk edge.
  - If it collides with an I2C write to the same address in the same cycle, the I2C write wins.
  - The read shift register is loaded once per byte, so host writes never corrupt a byte already in transmission.

## Timing
- Reset values:
  - Outputs: Tristate=0, SDA_out=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - Internal: FSM=IDLE, ptr=0, regfile initialized to the reset values above.
- Reset deassertion mid-transaction: the block stays in IDLE until the next START.
- Event latency: 3 clk cycles from a raw pin edge to the decoded event.
- Tristate changes 1 clk after a decoded SCL fall. It is held through the whole following SCL-high phase and released on the SCL fall ending the ACK or data bit.
- wr_strobe asserts 1 clk after the 8th SCL rise of a data byte.
- busy rises on the clk after the address byte's 8th SCL rise when the address matches, and falls 1 clk after STOP is decoded.

## Test plan
- Write 0x68<<1|0, reg 0x6B, data 0x00, STOP -> three ACKs; wr_strobe once with wr_addr=0x6B and wr_data=0x00; a later read of 0x6B returns 0x00.
- Write pointer 0x75, repeated START, 0xD1, read 1 byte with NACK, STOP -> returns 0x68; Tristate=0 after the NACK.
- host writes 0x12 to 0x43 and 0x34 to 0x44; I2C burst read from 0x43, 2 bytes (ACK then NACK) -> 0x12, 0x34; ptr ends at 0x45.
- Address 0x69 -> no ACK (Tristate never 1); busy stays 0; subsequent bytes ignored until STOP.
- Burst write of 3 bytes starting at 0x7F -> registers 0x7F, 0x00, 0x01 written; three wr_strobe pulses.
- Drive reset low in the middle of RDATA -> Tristate=0 immediately; after release, the FSM ignores the bus until a new START and responds normally.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target emulating a 128 x 8 register map (MPU6050 style) with auto-incrementing pointer,
// plus a fabric port to preload registers and observe completed I2C writes.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter logic [7:0] WHOAMI_VAL = 8'h68
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_out,
    output logic       Tristate,
    input  logic       host_we,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    logic          r_scl_s1, r_scl_s2, r_scl_d;
    logic          r_sda_s1, r_sda_s2, r_sda_d;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic [DW-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_tristate, w_tristate_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_strobe, w_strobe_nxt;
    logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DW-1:0] r_wr_data, w_wr_data_nxt;
    logic          w_i2c_we;
    logic [DW-1:0] w_byte;
    logic [DW-1:0] w_rd_byte;

    logic [DW-1:0] r_regfile [DEPTH];

    // Bus lines idle high, so synchronizers reset to 1 to avoid phantom edges after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= SCL;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= SDA_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[DW-2:0], r_sda_s2};
    assign w_rd_byte  = r_regfile[r_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_tristate <= 1'b0;
            r_busy     <= 1'b0;
            r_strobe   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rw       <= w_rw_nxt;
            r_tristate <= w_tristate_nxt;
            r_busy     <= w_busy_nxt;
            r_strobe   <= w_strobe_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    // ACK states use the first SCL fall to start driving and the second to release.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_rw_nxt       = r_rw;
        w_tristate_nxt = r_tristate;
        w_busy_nxt     = r_busy;
        w_strobe_nxt   = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_i2c_we       = 1'b0;

        if (w_stop) begin
            w_state_nxt    = S_IDLE;
            w_busy_nxt     = 1'b0;
            w_tristate_nxt = 1'b0;
            w_cnt_nxt      = '0;
        end else if (w_start) begin
            w_state_nxt    = S_ADDR;
            w_tristate_nxt = 1'b0;
            w_cnt_nxt      = '0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        if (r_cnt == CW'(7)) begin
                            w_cnt_nxt = '0;
                            if (w_byte[DW-1:1] == DEV_ADDR) begin
                                w_rw_nxt    = w_byte[0];
                                w_busy_nxt  = 1'b1;
                                w_state_nxt = S_ADDR_ACK;
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_tristate) begin
                            w_tristate_nxt = 1'b1;
                        end else if (r_rw) begin
                            w_shift_nxt    = w_rd_byte;
                            w_tristate_nxt = ~w_rd_byte[DW-1];
                            w_cnt_nxt      = '0;
                            w_state_nxt    = S_RDATA;
                        end else begin
                            w_tristate_nxt = 1'b0;
                            w_cnt_nxt      = '0;
                            w_state_nxt    = S_REG;
                        end
                    end
                end
                S_REG: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        if (r_cnt == CW'(7)) begin
                            w_cnt_nxt   = '0;
                            w_ptr_nxt   = w_byte[AW-1:0];
                            w_state_nxt = S_REG_ACK;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                S_REG_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_tristate) begin
                            w_tristate_nxt = 1'b1;
                        end else begin
                            w_tristate_nxt = 1'b0;
                            w_cnt_nxt      = '0;
                            w_state_nxt    = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        if (r_cnt == CW'(7)) begin
                            w_cnt_nxt     = '0;
                            w_i2c_we      = 1'b1;
                            w_strobe_nxt  = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = w_byte;
                            w_ptr_nxt     = r_ptr + AW'(1);
                            w_state_nxt   = S_WDATA_ACK;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && r_cnt != CW'(8)) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end else if (w_scl_fall && r_cnt == CW'(8)) begin
                        w_tristate_nxt = 1'b0;
                        w_cnt_nxt      = '0;
                        w_ptr_nxt      = r_ptr + AW'(1);
                        w_state_nxt    = S_RDATA_ACK;
                    end else if (w_scl_fall && r_cnt != '0) begin
                        w_shift_nxt    = {r_shift[DW-2:0], 1'b0};
                        w_tristate_nxt = ~r_shift[DW-2];
                    end
                end
                S_RDATA_ACK: begin
                    // r_cnt doubles as a flag that the master ACKed and the next byte is loaded.
                    if (w_scl_rise) begin
                        if (r_sda_s2) begin
                            w_state_nxt = S_WAIT_STOP;
                        end else begin
                            w_shift_nxt = w_rd_byte;
                            w_cnt_nxt   = CW'(1);
                        end
                    end else if (w_scl_fall && r_cnt == CW'(1)) begin
                        w_tristate_nxt = ~r_shift[DW-1];
                        w_cnt_nxt      = '0;
                        w_state_nxt    = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // I2C write is applied after the host write so it wins on an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regfile[AW'(i)] <= (i == 32'h75) ? WHOAMI_VAL :
                                     (i == 32'h6B) ? 8'h40 : 8'h00;
            end
        end else begin
            if (host_we) begin
                r_regfile[host_addr] <= host_wdata;
            end
            if (w_i2c_we) begin
                r_regfile[r_ptr] <= w_byte;
            end
        end
    end

    assign SDA_out   = 1'b0;
    assign Tristate  = r_tristate;
    assign busy      = r_busy;
    assign wr_strobe = r_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Scoreboard bench for i2c_slave_regfile: the bench acts as I2C master on an open-drain SDA model.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_out, tri_o;
    logic       host_we;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda_line = sda_m & ~tri_o;

    i2c_slave_regfile dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA_in(sda_line),
        .SDA_out(sda_out), .Tristate(tri_o),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] wr_exp_q[$];
    logic [7:0]  rd_exp_q[$], rd_obs_q[$];
    logic        ack_exp_q[$], ack_obs_q[$];
    logic        watch = 1'b0, tri_seen = 1'b0, busy_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT output with no expectation queued at %0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write strobe, a read byte or an ACK bit.
    logic [14:0] m_wr;
    logic [7:0]  m_rd;
    logic        m_ack;
    always @(negedge clk) begin
        if (wr_strobe) begin
            if (wr_exp_q.size() == 0) unexpected("wr_strobe");
            else begin
                m_wr = wr_exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(m_wr[14:8]));
                chk("wr_data", 32'(wr_data), 32'(m_wr[7:0]));
            end
        end
        while (rd_obs_q.size() > 0) begin
            m_rd = rd_obs_q.pop_front();
            if (rd_exp_q.size() == 0) unexpected("rd_byte");
            else chk("rd_byte", 32'(m_rd), 32'(rd_exp_q.pop_front()));
        end
        while (ack_obs_q.size() > 0) begin
            m_ack = ack_obs_q.pop_front();
            if (ack_exp_q.size() == 0) unexpected("ack_bit");
            else chk("ack_bit", 32'(m_ack), 32'(ack_exp_q.pop_front()));
        end
        if (watch) begin
            if (tri_o) tri_seen = 1'b1;
            if (busy)  busy_seen = 1'b1;
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        ack_exp_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q;
        ack_obs_q.push_back(sda_line);
        #Q; scl = 1'b0; #Q;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic nack);
        logic [7:0] v;
        v = '0;
        rd_exp_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; #Q; scl = 1'b1; #Q;
            v = {v[6:0], sda_line};
            #Q; scl = 1'b0; #Q;
        end
        rd_obs_q.push_back(v);
        bit_out(nack);
        sda_m = 1'b1;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic set_ptr_and_read(input logic [6:0] r);
        i2c_start(); send_byte(8'hD0, 1'b0); send_byte({1'b0, r}, 1'b0);
        i2c_start(); send_byte(8'hD1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; scl = 1'b1; sda_m = 1'b1;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #25;
        chk("rst_tristate", 32'(tri_o), 0);
        chk("rst_sda_out", 32'(sda_out), 0);
        chk("rst_wr_strobe", 32'(wr_strobe), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk); reset = 1'b1;
        repeat (5) @(negedge clk);

        // Register write of 0x6B, then read back.
        wr_exp_q.push_back({7'h6B, 8'h00});
        i2c_start(); send_byte(8'hD0, 1'b0);
        chk("busy_after_addr", 32'(busy), 1);
        send_byte(8'h6B, 1'b0); send_byte(8'h00, 1'b0);
        i2c_stop(); #Q;
        chk("busy_after_stop", 32'(busy), 0);
        set_ptr_and_read(7'h6B); recv_byte(8'h00, 1'b1); i2c_stop(); #Q;

        // WHO_AM_I via repeated start, Tristate released after NACK.
        set_ptr_and_read(7'h75); recv_byte(8'h68, 1'b1);
        chk("tri_after_nack", 32'(tri_o), 0);
        i2c_stop(); #Q;

        // Host preload and burst read; the pointer ends past the last byte sent.
        host_write(7'h43, 8'h12); host_write(7'h44, 8'h34); host_write(7'h45, 8'h56);
        set_ptr_and_read(7'h43); recv_byte(8'h12, 1'b0); recv_byte(8'h34, 1'b1); i2c_stop(); #Q;
        i2c_start(); send_byte(8'hD1, 1'b0); recv_byte(8'h56, 1'b1); i2c_stop(); #Q;

        // Wrong device address: never ACKed, never busy, following bytes ignored.
        tri_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
        i2c_start(); send_byte(8'hD2, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        i2c_stop(); #Q;
        watch = 1'b0;
        chk("nomatch_tristate", 32'(tri_seen), 0);
        chk("nomatch_busy", 32'(busy_seen), 0);

        // Burst write wrapping the pointer 0x7F -> 0x00 -> 0x01, then read back.
        wr_exp_q.push_back({7'h7F, 8'hA1});
        wr_exp_q.push_back({7'h00, 8'hA2});
        wr_exp_q.push_back({7'h01, 8'hA3});
        i2c_start(); send_byte(8'hD0, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0); send_byte(8'hA3, 1'b0);
        i2c_stop(); #Q;
        set_ptr_and_read(7'h7F);
        recv_byte(8'hA1, 1'b0); recv_byte(8'hA2, 1'b0); recv_byte(8'hA3, 1'b1);
        i2c_stop(); #Q;

        // Reset asserted in the middle of a read byte.
        host_write(7'h20, 8'h00);
        set_ptr_and_read(7'h20);
        for (int i = 0; i < 3; i++) begin
            sda_m = 1'b1; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
        chk("tri_driving_zero", 32'(tri_o), 1);
        #3 reset = 1'b0;
        #1;
        chk("tri_in_reset", 32'(tri_o), 0);
        chk("busy_in_reset", 32'(busy), 0);
        #(2*Q);
        @(negedge clk); reset = 1'b1;
        tri_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
        for (int i = 0; i < 14; i++) begin
            sda_m = 1'b1; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
        i2c_stop(); #Q;
        watch = 1'b0;
        chk("post_reset_tristate", 32'(tri_seen), 0);
        chk("post_reset_busy", 32'(busy_seen), 0);
        set_ptr_and_read(7'h75); recv_byte(8'h68, 1'b1); i2c_stop();

        #(10*Q);
        chk("wr_q_drained", 32'(wr_exp_q.size()), 0);
        chk("rd_q_drained", 32'(rd_exp_q.size()), 0);
        chk("ack_q_drained", 32'(ack_exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
